// File: rtl/shared_data_tx_sched.sv
// shared_data_tx_sched: reads enabled shared-memory segments over an AXI4-lite
// read master and frames each as SOF / data words / EOF on the xcvr TX word
// stream, one word per tx_ena slot, comma (IDLE) words otherwise.
// Optional build macro: SHARED_DATA_TX_CHKSUM_EN puts a 16-bit sum of the
// data half-words into the EOF word; without it the field is zero.
module shared_data_tx_sched #(
  parameter int DW        = 32,
  parameter int AW        = 11,
  parameter int SEG_WORDS = 16,
  parameter int SEG_COUNT = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEG_COUNT-1:0] seg_mask,
  input  logic                 tx_ena,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_err,
  output logic [7:0]           underrun_cnt,
  output logic [AW-1:0]        araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [DW-1:0]        rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [DW-1:0]        tx_data,
  output logic [DW/8-1:0]      tx_iskey
);

  localparam int SW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
  localparam int WW = $clog2(SEG_WORDS + 1);
  localparam int KW = DW / 8;
  localparam logic [DW-1:0] IDLE_W = 32'h0000_00BC;
  localparam logic [KW-1:0] KEY_K0 = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] KEY_D  = '0;

  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF, ST_NEXT} state_t;

  state_t                 state_q, state_d;
  logic [SEG_COUNT-1:0]   mask_q, mask_d, rem;
  logic [SW-1:0]          seg_q, seg_d;
  logic [WW-1:0]          w_q, w_d;       // data words emitted in this segment
  logic [WW-1:0]          fw_q, fw_d;     // reads issued for this segment
  logic [DW-1:0]          buf_q, buf_d;
  logic                   buf_vld_q, buf_vld_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [AW-1:0]          araddr_q, araddr_d;
  logic                   done_q, done_d;
  logic                   rd_err_q, rd_err_d;
  logic [7:0]             und_q, und_d;
  logic [DW-1:0]          tx_data_q, tx_data_d;
  logic [KW-1:0]          tx_iskey_q, tx_iskey_d;
  logic                   consume;
  logic [15:0]            chk_field;
`ifdef SHARED_DATA_TX_CHKSUM_EN
  logic [15:0]            chk_q, chk_d;
`endif

  // Byte address of word w of segment s; wraps modulo 2^AW.
  function automatic logic [AW-1:0] addr_of(input logic [SW-1:0] s, input logic [WW-1:0] w);
    return AW'(BASE_ADDR + (int'(s) * SEG_WORDS + int'(w)) * 4);
  endfunction

  // Index of the lowest set bit (0 when none set).
  function automatic logic [SW-1:0] low_idx(input logic [SEG_COUNT-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    for (int i = SEG_COUNT - 1; i >= 0; i--) begin
      if (m[i]) r = SW'(i);
    end
    return r;
  endfunction

`ifdef SHARED_DATA_TX_CHKSUM_EN
  assign chk_field = chk_q;
`else
  assign chk_field = 16'h0000;
`endif

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      seg_q      <= '0;
      w_q        <= '0;
      fw_q       <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      done_q     <= 1'b0;
      rd_err_q   <= 1'b0;
      und_q      <= '0;
      tx_data_q  <= IDLE_W;
      tx_iskey_q <= KEY_K0;
`ifdef SHARED_DATA_TX_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      seg_q      <= seg_d;
      w_q        <= w_d;
      fw_q       <= fw_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      done_q     <= done_d;
      rd_err_q   <= rd_err_d;
      und_q      <= und_d;
      tx_data_q  <= tx_data_d;
      tx_iskey_q <= tx_iskey_d;
`ifdef SHARED_DATA_TX_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Next-state: frame sequencer, slot output mux and single-outstanding fetch engine.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    seg_d      = seg_q;
    w_d        = w_q;
    fw_d       = fw_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    done_d     = 1'b0;
    rd_err_d   = rd_err_q;
    und_d      = und_q;
    tx_data_d  = tx_data_q;
    tx_iskey_d = tx_iskey_q;
    consume    = 1'b0;
    rem        = mask_q;
    rem[seg_q] = 1'b0;
`ifdef SHARED_DATA_TX_CHKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_ena) begin
          tx_data_d  = IDLE_W;
          tx_iskey_d = KEY_K0;
        end
        if (start) begin
          und_d    = '0;
          rd_err_d = 1'b0;
          if (seg_mask != '0) begin
            mask_d    = seg_mask;
            seg_d     = low_idx(seg_mask);
            state_d   = ST_SOF;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(low_idx(seg_mask), '0);
            fw_d      = WW'(1);
            w_d       = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SOF: begin
        if (tx_ena) begin
          tx_data_d  = {8'h00, 8'(seg_q), 8'h00, 8'hFB};
          tx_iskey_d = KEY_K0;
          state_d    = ST_DATA;
`ifdef SHARED_DATA_TX_CHKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      ST_DATA: begin
        if (tx_ena) begin
          if (buf_vld_q) begin
            tx_data_d  = buf_q;
            tx_iskey_d = KEY_D;
            consume    = 1'b1;
            w_d        = w_q + 1'b1;
`ifdef SHARED_DATA_TX_CHKSUM_EN
            chk_d      = chk_q + buf_q[31:16] + buf_q[15:0];
`endif
            if (w_q == WW'(SEG_WORDS - 1)) state_d = ST_EOF;
          end else begin
            // Fetch latency lost this slot: emit a comma and count it.
            tx_data_d  = IDLE_W;
            tx_iskey_d = KEY_K0;
            if (und_q != 8'hFF) und_d = und_q + 8'd1;
          end
        end
      end
      ST_EOF: begin
        if (tx_ena) begin
          tx_data_d  = {chk_field, 8'h00, 8'hFD};
          tx_iskey_d = KEY_K0;
          state_d    = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (tx_ena) begin
          tx_data_d  = IDLE_W;
          tx_iskey_d = KEY_K0;
        end
        mask_d = rem;
        if (rem != '0) begin
          seg_d     = low_idx(rem);
          state_d   = ST_SOF;
          arvalid_d = 1'b1;
          araddr_d  = addr_of(low_idx(rem), '0);
          fw_d      = WW'(1);
          w_d       = '0;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    // Capture only ever lands in an empty buffer: a read is issued only when it is free.
    if (rready_q && rvalid) begin
      rready_d  = 1'b0;
      buf_d     = rdata;
      buf_vld_d = 1'b1;
      if (rresp != 2'b00) rd_err_d = 1'b1;
    end
    if (consume) buf_vld_d = 1'b0;
    if ((state_q == ST_SOF || state_q == ST_DATA) && !arvalid_q && !rready_q &&
        (!buf_vld_q || consume) && (fw_q < WW'(SEG_WORDS))) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_of(seg_q, fw_q);
      fw_d      = fw_q + 1'b1;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign rd_err       = rd_err_q;
  assign underrun_cnt = und_q;
  assign araddr       = araddr_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign tx_data      = tx_data_q;
  assign tx_iskey     = tx_iskey_q;

endmodule

// File: tb/tb_shared_data_tx_sched.sv
// Scoreboard bench for shared_data_tx_sched: expected frame words and read
// addresses are queued at each start from a memory image; a stream monitor and
// an AXI slave model pop and compare as the DUT produces them.
module tb_shared_data_tx_sched;
  localparam int DW = 32, AW = 11, SEG_WORDS = 4, SEG_COUNT = 4, BASE_ADDR = 0;
  localparam logic [31:0] IDLE_W = 32'h0000_00BC;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ena = 1'b0;
  logic [SEG_COUNT-1:0] seg_mask = '0;
  logic busy, done, rd_err, arvalid, rready;
  logic [7:0] underrun_cnt;
  logic [AW-1:0] araddr;
  logic arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic [31:0] tx_data;
  logic [3:0] tx_iskey;

  always #5 clk = ~clk;

  shared_data_tx_sched #(.DW(DW), .AW(AW), .SEG_WORDS(SEG_WORDS), .SEG_COUNT(SEG_COUNT),
                         .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .seg_mask(seg_mask), .tx_ena(tx_ena),
    .busy(busy), .done(done), .rd_err(rd_err), .underrun_cnt(underrun_cnt),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .tx_data(tx_data), .tx_iskey(tx_iskey)
  );

  int n_checks = 0, n_fail = 0;
  logic [31:0] mem [0:(1<<AW)/4-1];
  int rd_delay = 0, ar_pct = 100, ena_pct = 100;
  bit err_en = 1'b0, exp_err = 1'b0, in_frame = 1'b0, ena_seen = 1'b0;
  logic [AW-1:0] err_addr = '0;
  word_t exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int idle_in_frame = 0, done_seen = 0, exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [AW-1:0] a_of(input int s, input int w);
    return AW'(BASE_ADDR + (s * SEG_WORDS + w) * 4);
  endfunction

  // Slot strobe generator.
  initial forever begin
    @(posedge clk); #1;
    tx_ena = ($urandom_range(0, 99) < ena_pct);
  end

  always @(posedge clk) ena_seen <= tx_ena;

  // Stream monitor: every non-comma word consumed by a slot must match the queue head.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (ena_seen && !rst) begin
        if (tx_data == IDLE_W && tx_iskey == 4'b0001) begin
          if (in_frame) idle_in_frame++;
        end else begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL stream_extra: got %h key %b, expected no word", tx_data, tx_iskey);
          end else begin
            e = exp_q.pop_front();
            chk("stream_word", tx_data, e.d);
            chk("stream_key", 32'(tx_iskey), 32'(e.k));
          end
          if (tx_iskey == 4'b0001 && tx_data[7:0] == 8'hFB) in_frame = 1'b1;
          if (tx_iskey == 4'b0001 && tx_data[7:0] == 8'hFD) in_frame = 1'b0;
        end
      end
    end
  end

  // AXI4-lite read slave: samples handshakes at negedge, updates after posedge.
  initial begin
    bit hs_ar, hs_r, pend;
    logic [AW-1:0] a_s, cur;
    int cnt;
    pend = 1'b0; cnt = 0; cur = '0;
    forever begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      a_s   = araddr;
      @(posedge clk); #1;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; pend = 1'b0;
      end else begin
        if (hs_r) rvalid = 1'b0;
        if (hs_ar) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL araddr_extra: got %h expected no read", a_s);
          end else chk("araddr", 32'(a_s), 32'(exp_addr_q.pop_front()));
          pend = 1'b1; cnt = rd_delay; cur = a_s;
        end
        if (pend) begin
          if (cnt == 0) begin
            rvalid = 1'b1;
            rdata  = mem[cur[AW-1:2]];
            rresp  = (err_en && cur == err_addr) ? 2'b10 : 2'b00;
            pend   = 1'b0;
          end else cnt--;
        end
        arready = ($urandom_range(0, 99) < ar_pct);
      end
    end
  end

  task automatic do_start(input logic [3:0] m);
    int t;
    logic [15:0] c;
    logic [AW-1:0] a;
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin n_checks++; n_fail++; $display("FAIL idle_timeout: got busy=1 expected busy=0"); end
    @(posedge clk); #1;
    exp_err = 1'b0;
    idle_in_frame = 0;
    for (int s = 0; s < SEG_COUNT; s++) begin
      if (m[s]) begin
        exp_q.push_back('{d: {8'h00, 8'(s), 8'h00, 8'hFB}, k: 4'b0001});
        c = 16'h0000;
        for (int w = 0; w < SEG_WORDS; w++) begin
          a = a_of(s, w);
          exp_addr_q.push_back(a);
          exp_q.push_back('{d: mem[a[AW-1:2]], k: 4'b0000});
          c = c + mem[a[AW-1:2]][31:16] + mem[a[AW-1:2]][15:0];
          if (err_en && a == err_addr) exp_err = 1'b1;
        end
`ifndef SHARED_DATA_TX_CHKSUM_EN
        c = 16'h0000;
`endif
        exp_q.push_back('{d: {c, 8'h00, 8'hFD}, k: 4'b0001});
      end
    end
    start = 1'b1; seg_mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'(m != 0));
    chk("start_done", 32'(done), 32'(m == 0));
    chk("start_rd_err_clr", 32'(rd_err), 0);
    chk("start_underrun_clr", 32'(underrun_cnt), 0);
    if (m == 0) exp_done++;
  endtask

  task automatic wait_done();
    int t;
    int eu;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected pulse", t);
    end else exp_done++;
    eu = (idle_in_frame > 255) ? 255 : idle_in_frame;
    chk("frames_complete", 32'(exp_q.size()), 0);
    chk("reads_complete", 32'(exp_addr_q.size()), 0);
    chk("underrun_cnt", 32'(underrun_cnt), 32'(eu));
    chk("rd_err", 32'(rd_err), 32'(exp_err));
    chk("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    for (int i = 0; i < (1<<AW)/4; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h5555AAAA; mem[2] = 32'h11112222; mem[3] = 32'h33334444;

    // Reset values.
    ena_pct = 50;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_underrun", 32'(underrun_cnt), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_araddr", 32'(araddr), 0);
    chk("rst_tx_data", tx_data, IDLE_W);
    chk("rst_tx_iskey", 32'(tx_iskey), 1);
    @(posedge clk); #1 rst = 1'b0;

    // No start: comma stream forever, never busy.
    repeat (12) begin
      @(negedge clk);
      chk("idle_tx_data", tx_data, IDLE_W);
      chk("idle_busy", 32'(busy), 0);
    end

    // Single segment, fast slave.
    ena_pct = 100; rd_delay = 0; ar_pct = 100;
    do_start(4'b0001); wait_done();

    // Two segments, addresses 0x10.. and 0x30..
    ena_pct = 60;
    do_start(4'b1010); wait_done();

    // Slow slave with a slot every cycle: underruns must appear and be counted.
    ena_pct = 100; rd_delay = 6;
    do_start(4'b0101); wait_done();
    chk("underrun_nonzero", 32'(underrun_cnt != 0), 1);

    // Error response on word 2 of segment 2; a start while busy is ignored.
    rd_delay = 1; err_en = 1'b1; err_addr = a_of(2, 2);
    do_start(4'b0100);
    @(posedge clk); #1 start = 1'b1; seg_mask = 4'b1000;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    err_en = 1'b0;
    do_start(4'b0001); wait_done();

    // Empty mask: done pulse, never busy.
    do_start(4'b0000);

    // Reset in the middle of DATA, then a clean frame.
    rd_delay = 0; ena_pct = 100;
    do_start(4'b0011);
    for (int t = 0; t < 500 && !in_frame; t++) @(negedge clk);
    chk("reached_data", 32'(in_frame), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    exp_q.delete(); exp_addr_q.delete(); in_frame = 1'b0;
    @(negedge clk);
    chk("midrst_arvalid", 32'(arvalid), 0);
    chk("midrst_rready", 32'(rready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_data", tx_data, IDLE_W);
    chk("midrst_tx_iskey", 32'(tx_iskey), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_start(4'b0010); wait_done();

    // Randomized sequences.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < SEG_COUNT * SEG_WORDS; j++) mem[j] = $urandom;
      rd_delay = $urandom_range(0, 4);
      ar_pct   = $urandom_range(30, 100);
      ena_pct  = $urandom_range(20, 100);
      m = 4'($urandom_range(0, 15));
      do_start(m);
      if (m != 0) wait_done();
    end

    repeat (4) @(negedge clk);
    chk("done_count", 32'(done_seen), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
